pe_operand_feeder: RTL and testbench

- Drives one PE MAC cell for a single-channel valid convolution: IMG_W x IMG_H image, K x K kernel, stride 1.
- Reads image and kernel pixels from two 1-cycle-latency read ports and streams one tap per cycle into the PE.
- Feeds the PE's registered output back as part_sum, so the PE accumulates the K*K taps of one window.
- Returns each finished window sum on a valid/ready result port, in raster order.

---
 rtl/pe_operand_feeder.sv | 172 +++++++++++++++++
 tb/tb_pe_operand_feeder.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_operand_feeder.sv
// Operand feeder for one PE MAC cell: K x K valid convolution, stride 1, with a valid/ready result port.
// Define PE_FEEDER_POS_TAG_EN to add res_row/res_col window position outputs.
module pe_operand_feeder #(
    parameter int IMAGE_PIXEL_WIDTH  = 8,
    parameter int KERNEL_PIXEL_WIDTH = 8,
    parameter int IMG_W              = 32,
    parameter int IMG_H              = 32,
    parameter int K                  = 5,
    parameter int IMG_ADDR_WIDTH     = 10,
    parameter int KER_ADDR_WIDTH     = 5
) (
    input  logic                                          clock,
    input  logic                                          rst,
    input  logic                                          start,
    output logic                                          busy,
    output logic                                          done,
    output logic                                          img_rd_en,
    output logic [IMG_ADDR_WIDTH-1:0]                     img_rd_addr,
    input  logic [IMAGE_PIXEL_WIDTH-1:0]                  img_rd_data,
    output logic                                          ker_rd_en,
    output logic [KER_ADDR_WIDTH-1:0]                     ker_rd_addr,
    input  logic [KERNEL_PIXEL_WIDTH-1:0]                 ker_rd_data,
    output logic                                          pe_en,
    output logic [IMAGE_PIXEL_WIDTH-1:0]                  pe_in1,
    output logic [KERNEL_PIXEL_WIDTH-1:0]                 pe_in2,
    output logic [IMAGE_PIXEL_WIDTH+KERNEL_PIXEL_WIDTH-1:0] pe_part_sum,
    input  logic [IMAGE_PIXEL_WIDTH+KERNEL_PIXEL_WIDTH-1:0] pe_data_out,
    output logic                                          res_valid,
    input  logic                                          res_ready,
    output logic [IMAGE_PIXEL_WIDTH+KERNEL_PIXEL_WIDTH-1:0] res_data
`ifdef PE_FEEDER_POS_TAG_EN
    ,
    output logic [IMG_ADDR_WIDTH-1:0]                     res_row,
    output logic [IMG_ADDR_WIDTH-1:0]                     res_col
`endif
);

    localparam int SW = IMAGE_PIXEL_WIDTH + KERNEL_PIXEL_WIDTH;

    localparam logic [IMG_ADDR_WIDTH-1:0] R_LAST = IMG_ADDR_WIDTH'(IMG_H - K);
    localparam logic [IMG_ADDR_WIDTH-1:0] C_LAST = IMG_ADDR_WIDTH'(IMG_W - K);
    localparam logic [IMG_ADDR_WIDTH-1:0] W_A    = IMG_ADDR_WIDTH'(IMG_W);
    localparam logic [KER_ADDR_WIDTH-1:0] K_LAST = KER_ADDR_WIDTH'(K - 1);
    localparam logic [KER_ADDR_WIDTH-1:0] K_A    = KER_ADDR_WIDTH'(K);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_TAIL,
        S_DRAIN,
        S_OUT,
        S_FIN
    } state_t;

    state_t                    state_q, state_d;
    logic [IMG_ADDR_WIDTH-1:0] r_q, r_d, c_q, c_d;
    logic [KER_ADDR_WIDTH-1:0] kr_q, kr_d, kc_q, kc_d;
    logic                      pe_en_q;
    logic                      first_q;
    logic [SW-1:0]             res_data_q;
    logic                      rd_active;
`ifdef PE_FEEDER_POS_TAG_EN
    logic [IMG_ADDR_WIDTH-1:0] res_row_q, res_col_q;
`endif

    assign rd_active = (state_q == S_RUN);

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        c_d     = c_q;
        kr_d    = kr_q;
        kc_d    = kc_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    r_d     = '0;
                    c_d     = '0;
                    kr_d    = '0;
                    kc_d    = '0;
                end
            end
            S_RUN: begin
                // Tap counters wrap back to zero here, so OUT only has to step the window.
                if (kc_q == K_LAST) begin
                    kc_d = '0;
                    if (kr_q == K_LAST) begin
                        kr_d    = '0;
                        state_d = S_TAIL;
                    end else begin
                        kr_d = kr_q + 1'b1;
                    end
                end else begin
                    kc_d = kc_q + 1'b1;
                end
            end
            S_TAIL:  state_d = S_DRAIN;
            S_DRAIN: state_d = S_OUT;
            S_OUT: begin
                if (res_ready) begin
                    if (r_q == R_LAST && c_q == C_LAST) begin
                        state_d = S_FIN;
                    end else begin
                        state_d = S_RUN;
                        if (c_q == C_LAST) begin
                            c_d = '0;
                            r_d = r_q + 1'b1;
                        end else begin
                            c_d = c_q + 1'b1;
                        end
                    end
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q    <= S_IDLE;
            r_q        <= '0;
            c_q        <= '0;
            kr_q       <= '0;
            kc_q       <= '0;
            pe_en_q    <= 1'b0;
            first_q    <= 1'b0;
            res_data_q <= '0;
`ifdef PE_FEEDER_POS_TAG_EN
            res_row_q  <= '0;
            res_col_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            c_q     <= c_d;
            kr_q    <= kr_d;
            kc_q    <= kc_d;
            pe_en_q <= rd_active;
            first_q <= rd_active && (kr_q == '0) && (kc_q == '0);
            if (state_q == S_DRAIN) begin
                res_data_q <= pe_data_out;
`ifdef PE_FEEDER_POS_TAG_EN
                res_row_q  <= r_q;
                res_col_q  <= c_q;
`endif
            end
        end
    end

    assign img_rd_en   = rd_active;
    assign ker_rd_en   = rd_active;
    assign img_rd_addr = rd_active ? ((r_q + IMG_ADDR_WIDTH'(kr_q)) * W_A + c_q + IMG_ADDR_WIDTH'(kc_q)) : '0;
    assign ker_rd_addr = rd_active ? (kr_q * K_A + kc_q) : '0;

    // Read data arrives one cycle after the strobe, which is exactly when pe_en_q is high.
    assign pe_en       = pe_en_q;
    assign pe_in1      = pe_en_q ? img_rd_data : '0;
    assign pe_in2      = pe_en_q ? ker_rd_data : '0;
    assign pe_part_sum = (pe_en_q && !first_q) ? pe_data_out : '0;

    assign res_valid = (state_q == S_OUT);
    assign res_data  = res_data_q;
    assign busy      = (state_q != S_IDLE) && (state_q != S_FIN);
    assign done      = (state_q == S_FIN);
`ifdef PE_FEEDER_POS_TAG_EN
    assign res_row   = res_row_q;
    assign res_col   = res_col_q;
`endif

endmodule

// File: tb/tb_pe_operand_feeder.sv
// Bench for pe_operand_feeder on a 4x4 image with a 2x2 kernel, with memory and PE models and a result scoreboard.
`timescale 1ns/1ps
module tb_pe_operand_feeder;

    localparam int IPW  = 8;
    localparam int KPW  = 8;
    localparam int IW   = 4;
    localparam int IH   = 4;
    localparam int KK   = 2;
    localparam int IAW  = 4;
    localparam int KAW  = 5;
    localparam int SW   = IPW + KPW;
    localparam int NRES = (IW - KK + 1) * (IH - KK + 1);

    logic           clock = 1'b0;
    logic           rst, start, res_ready;
    logic           busy, done, img_rd_en, ker_rd_en, pe_en, res_valid;
    logic [IAW-1:0] img_rd_addr;
    logic [KAW-1:0] ker_rd_addr;
    logic [IPW-1:0] img_rd_data = '0;
    logic [KPW-1:0] ker_rd_data = '0;
    logic [IPW-1:0] pe_in1;
    logic [KPW-1:0] pe_in2;
    logic [SW-1:0]  pe_part_sum, res_data;
    logic [SW-1:0]  pe_data_out = '0;
`ifdef PE_FEEDER_POS_TAG_EN
    logic [IAW-1:0] res_row, res_col;
`endif

    always #5 clock = ~clock;

    pe_operand_feeder #(
        .IMAGE_PIXEL_WIDTH (IPW),
        .KERNEL_PIXEL_WIDTH(KPW),
        .IMG_W             (IW),
        .IMG_H             (IH),
        .K                 (KK),
        .IMG_ADDR_WIDTH    (IAW),
        .KER_ADDR_WIDTH    (KAW)
    ) dut (
        .clock      (clock),
        .rst        (rst),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .img_rd_en  (img_rd_en),
        .img_rd_addr(img_rd_addr),
        .img_rd_data(img_rd_data),
        .ker_rd_en  (ker_rd_en),
        .ker_rd_addr(ker_rd_addr),
        .ker_rd_data(ker_rd_data),
        .pe_en      (pe_en),
        .pe_in1     (pe_in1),
        .pe_in2     (pe_in2),
        .pe_part_sum(pe_part_sum),
        .pe_data_out(pe_data_out),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data)
`ifdef PE_FEEDER_POS_TAG_EN
        ,
        .res_row    (res_row),
        .res_col    (res_col)
`endif
    );

    // Memories with one-cycle read latency and a registered MAC cell.
    logic [IPW-1:0] img_mem [0:IW*IH-1];
    logic [KPW-1:0] ker_mem [0:31];
    always @(posedge clock) begin
        if (img_rd_en) img_rd_data <= img_mem[img_rd_addr];
        if (ker_rd_en) ker_rd_data <= ker_mem[ker_rd_addr];
        if (rst) pe_data_out <= '0;
        else if (pe_en) pe_data_out <= {8'd0, pe_in1} * {8'd0, pe_in2} + pe_part_sum;
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic [62:0] out_vec;
    assign out_vec = {busy, done, img_rd_en, img_rd_addr, ker_rd_en, ker_rd_addr, pe_en,
                      pe_in1, pe_in2, pe_part_sum, res_valid, res_data};

    typedef struct packed {
        logic [SW-1:0]  data;
        logic [IAW-1:0] row;
        logic [IAW-1:0] col;
    } exp_t;

    typedef struct {
        int            img_mode;
        int            ker_mode;
        int            stall_at;
        int            stall_len;
        bit            glitch;
        bit            chk_addr;
        logic [SW-1:0] exp_first;
        logic [SW-1:0] exp_last;
    } vec_t;

    exp_t           sb[$];
    logic [IAW-1:0] addr_log[$];
    int             errors = 0;
    int             checks = 0;
    int             rd_cnt, done_cnt, n_res, first_valid, stall_cycles;
    logic [SW-1:0]  got_first, got_last;
    vec_t           tbl[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Output monitor, sampled on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (!rst) begin
                if (img_rd_en) begin
                    rd_cnt++;
                    if (addr_log.size() < 4) addr_log.push_back(img_rd_addr);
                end
                if (done) begin
                    done_cnt++;
                    check("busy_low_in_done", 64'(busy), 64'(0));
                end
                if (res_valid && first_valid < 0) first_valid = cyc;
                if (res_valid && !res_ready) begin
                    stall_cycles++;
                    if (sb.size() > 0) check("stall_hold_data", 64'(res_data), 64'(sb[0].data));
                    check("stall_no_rd_pe", 64'({img_rd_en, pe_en}), 64'(0));
                end
                if (res_valid && res_ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected_result", 64'(1), 64'(0));
                    end else begin
                        e = sb.pop_front();
                        check("result_data", 64'(res_data), 64'(e.data));
`ifdef PE_FEEDER_POS_TAG_EN
                        check("result_row", 64'(res_row), 64'(e.row));
                        check("result_col", 64'(res_col), 64'(e.col));
`endif
                    end
                    if (n_res == 0) got_first = res_data;
                    got_last = res_data;
                    n_res++;
                end
            end
        end
    end

    task automatic load_mem(input int img_mode, input int ker_mode);
        for (int a = 0; a < IW * IH; a++)
            img_mem[a] = (img_mode == 0) ? 8'd1 : (img_mode == 1) ? 8'(a) : 8'd255;
        for (int a = 0; a < 32; a++) ker_mem[a] = '0;
        for (int a = 0; a < KK * KK; a++)
            ker_mem[a] = (ker_mode == 0) ? 8'd1 : (ker_mode == 1) ? ((a == 0) ? 8'd1 : 8'd0) : 8'd255;
    endtask

    task automatic push_expected();
        logic [SW-1:0] s;
        for (int r = 0; r <= IH - KK; r++)
            for (int c = 0; c <= IW - KK; c++) begin
                s = '0;
                for (int kr = 0; kr < KK; kr++)
                    for (int kc = 0; kc < KK; kc++)
                        s = s + SW'(img_mem[(r + kr) * IW + c + kc]) * SW'(ker_mem[kr * KK + kc]);
                sb.push_back('{data: s, row: IAW'(r), col: IAW'(c)});
            end
    endtask

    task automatic clear_counters();
        rd_cnt = 0; done_cnt = 0; n_res = 0; first_valid = -1; stall_cycles = 0;
        got_first = '0; got_last = '0;
        addr_log.delete();
    endtask

    task automatic run_frame(input vec_t v);
        int            stall_left;
        int            s_cyc;
        logic [IAW-1:0] exp_a[4];
        exp_a = '{4'd0, 4'd1, 4'd4, 4'd5};
        load_mem(v.img_mode, v.ker_mode);
        clear_counters();
        stall_left = v.stall_len;
        @(posedge clock); #1;
        push_expected();
        start = 1'b1;
        s_cyc = cyc;
        @(posedge clock); #1;
        start = 1'b0;
        for (int t = 0; t < 400 && done_cnt == 0; t++) begin
            if (v.stall_at >= 0 && n_res == v.stall_at && res_valid && stall_left > 0) begin
                res_ready = 1'b0;
                stall_left--;
            end else begin
                res_ready = 1'b1;
            end
            start = v.glitch && ((img_rd_en && rd_cnt == 2) || (res_valid && n_res == 3));
            @(posedge clock); #1;
        end
        start = 1'b0;
        res_ready = 1'b1;
        repeat (6) @(posedge clock);
        #1;
        check("done_count", 64'(done_cnt), 64'(1));
        check("result_count", 64'(n_res), 64'(NRES));
        check("scoreboard_empty", 64'(sb.size()), 64'(0));
        check("busy_after_done", 64'(busy), 64'(0));
        check("first_valid_latency", 64'(first_valid - s_cyc), 64'(KK * KK + 3));
        check("first_result", 64'(got_first), 64'(v.exp_first));
        check("last_result", 64'(got_last), 64'(v.exp_last));
        if (v.chk_addr)
            for (int i = 0; i < 4; i++)
                check("win0_img_addr", 64'((i < addr_log.size()) ? addr_log[i] : 4'hF), 64'(exp_a[i]));
        if (v.stall_at >= 0)
            check("stall_cycles", 64'(stall_cycles), 64'(v.stall_len));
        sb.delete();
    endtask

    task automatic reset_midframe();
        int rd_before, res_before;
        load_mem(0, 0);
        clear_counters();
        @(posedge clock); #1;
        push_expected();
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        // Stop at the third RUN cycle of the second window (seventh read overall).
        for (int t = 0; t < 200; t++) begin
            if (img_rd_en && rd_cnt == 6) break;
            @(posedge clock); #1;
        end
        check("rst_point_reached", 64'(rd_cnt), 64'(6));
        rst = 1'b1;
        @(posedge clock); #1;
        check("rst_outputs_zero", 64'(out_vec), 64'(0));
`ifdef PE_FEEDER_POS_TAG_EN
        check("rst_tags_zero", 64'({res_row, res_col}), 64'(0));
`endif
        rst = 1'b0;
        sb.delete();
        rd_before = rd_cnt;
        res_before = n_res;
        repeat (12) @(posedge clock);
        #1;
        check("rst_no_done", 64'(done_cnt), 64'(0));
        check("rst_no_reads", 64'(rd_cnt - rd_before), 64'(0));
        check("rst_no_results", 64'(n_res - res_before), 64'(0));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; res_ready = 1'b1;
        clear_counters();
        repeat (3) @(posedge clock);
        #1;
        check("reset_outputs", 64'(out_vec), 64'(0));
        rst = 1'b0;

        //        img ker stall len glitch addr first   last
        tbl[0] = '{0, 0, -1, 0, 1'b0, 1'b0, 16'd4,     16'd4};
        tbl[1] = '{1, 1, -1, 0, 1'b0, 1'b1, 16'd0,     16'd10};
        tbl[2] = '{0, 0,  1, 5, 1'b0, 1'b0, 16'd4,     16'd4};
        tbl[3] = '{0, 0, -1, 0, 1'b1, 1'b0, 16'd4,     16'd4};
        tbl[4] = '{2, 2, -1, 0, 1'b0, 1'b0, 16'd63492, 16'd63492};

        for (int i = 0; i < 5; i++) run_frame(tbl[i]);
        reset_midframe();
        run_frame(tbl[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
